// File: rtl/mem_rd_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_rd_stage                                                 |
// | Description : Memory-read stage after address generation. Forms the       |
// |               linear address, checks it against the segment upper bound,  |
// |               reads the operand from the D-cache over a req/ack handshake |
// |               (two reads for dword-crossing accesses), then aligns and    |
// |               zero-extends the data into the execute-facing registers.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_v               AG uop valid
//   i_memRen/WEn      uop reads / writes memory (writes are limit-checked only)
//   i_virt_addr       effective address from AG
//   i_segRc           segment base high half, base = {i_segRc,16'h0}
//   i_seg_lim         inclusive linear upper bound
//   i_opSize          00/01 byte, 10 word, 11 dword
//   i_flush           squash the in-flight uop
//   i_ex_stall        execute cannot accept this cycle
//   o_stall           back-pressure to AG
//   o_dc_req/addr     D-cache read request, dword address
//   i_dc_ack/data     D-cache data valid / aligned dword
//   o_v, o_lin_addr   result valid, linear address of the access
//   o_mem_data        aligned, zero-extended operand
//   o_gp_fault        segment limit / wrap violation
//   o_bus_err         D-cache ack timeout
module mem_rd_stage #(
  parameter int TO_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_v,
  input  logic        i_memRen,
  input  logic        i_memWen,
  input  logic [31:0] i_virt_addr,
  input  logic [15:0] i_segRc,
  input  logic [31:0] i_seg_lim,
  input  logic [1:0]  i_opSize,
  input  logic        i_flush,
  input  logic        i_ex_stall,
  output logic        o_stall,
  output logic        o_dc_req,
  output logic [29:0] o_dc_addr,
  input  logic        i_dc_ack,
  input  logic [31:0] i_dc_data,
  output logic        o_v,
  output logic [31:0] o_lin_addr,
  output logic [31:0] o_mem_data,
  output logic        o_gp_fault,
  output logic        o_bus_err
);

  // S_DRAIN: uop was flushed while a request was outstanding; the request is
  // held until the D-cache acks so the handshake is never abandoned mid-way.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD0   = 2'd1,
    S_RD1   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int               c_cnt_w   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic             c_to_en   = (TO_CYC != 0);
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((TO_CYC > 0) ? (TO_CYC - 1) : 0);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_v;
  logic [31:0]         r_lin;
  logic [31:0]         r_data;
  logic                r_gp;
  logic                r_be;
  logic [29:0]         r_dc_addr;
  logic [1:0]          r_off;
  logic [1:0]          r_op;
  logic                r_split;
  logic [31:0]         r_lo;
  logic [c_cnt_w-1:0]  r_to_cnt;

  logic [31:0] w_lin;
  logic [2:0]  w_size;
  logic [32:0] w_end;
  logic        w_is_mem;
  logic        w_fault;
  logic        w_split;
  logic        w_accept;
  logic        w_rd_go;
  logic        w_busy;
  logic        w_in_rd;
  logic        w_to_hit;
  logic        w_done;
  logic        w_to_res;
  logic [63:0] w_pair;
  logic [31:0] w_shift;
  logic [31:0] w_asm;

  // Address formation and limit check on the incoming uop.
  assign w_lin    = i_virt_addr + {i_segRc, 16'h0000};
  assign w_size   = i_opSize[1] ? (i_opSize[0] ? 3'd4 : 3'd2) : 3'd1;
  assign w_end    = {1'b0, w_lin} + {30'd0, w_size} - 33'd1;
  assign w_is_mem = i_memRen | i_memWen;
  assign w_fault  = w_is_mem & (w_end[32] | (w_end[31:0] > i_seg_lim));
  assign w_split  = ({1'b0, w_lin[1:0]} + w_size) > 3'd4;

  assign w_busy   = (r_state != S_IDLE);
  assign w_in_rd  = (r_state == S_RD0) | (r_state == S_RD1);
  assign o_stall  = w_busy | (r_v & i_ex_stall);
  assign w_accept = i_v & ~o_stall & ~i_flush;
  assign w_rd_go  = w_accept & i_memRen & ~w_fault;

  // Timeout fires on the last allowed request cycle without an ack. It also
  // covers S_DRAIN so a dead D-cache cannot wedge the stage after a flush.
  assign w_to_hit = c_to_en & w_busy & ~i_dc_ack & (r_to_cnt == c_to_last);

  assign w_done   = i_dc_ack & (((r_state == S_RD0) & ~r_split) | (r_state == S_RD1));
  assign w_to_res = w_in_rd & w_to_hit;

  // Result assembly: the low dword is only registered for split accesses, and
  // the final ack's data is used directly so ack->o_v is a single cycle.
  assign w_pair  = (r_state == S_RD1) ? {i_dc_data, r_lo} : {32'd0, i_dc_data};
  assign w_shift = 32'(w_pair >> {r_off, 3'b000});

  always_comb begin
    w_asm = w_shift;
    case (r_op)
      2'b11:   w_asm = w_shift;
      2'b10:   w_asm = {16'd0, w_shift[15:0]};
      default: w_asm = {24'd0, w_shift[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_go) w_next_state = S_RD0;
      end
      S_RD0: begin
        if (i_dc_ack) begin
          // A flush coinciding with the first ack suppresses the second read.
          w_next_state = (r_split & ~i_flush) ? S_RD1 : S_IDLE;
        end else if (w_to_hit) begin
          w_next_state = S_IDLE;
        end else if (i_flush) begin
          w_next_state = S_DRAIN;
        end
      end
      S_RD1: begin
        if (i_dc_ack || w_to_hit) begin
          w_next_state = S_IDLE;
        end else if (i_flush) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_dc_ack || w_to_hit) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_dc_req = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v       <= 1'b0;
      r_lin     <= 32'd0;
      r_data    <= 32'd0;
      r_gp      <= 1'b0;
      r_be      <= 1'b0;
      r_dc_addr <= 30'd0;
      r_off     <= 2'd0;
      r_op      <= 2'd0;
      r_split   <= 1'b0;
      r_lo      <= 32'd0;
      r_to_cnt  <= '0;
    end else begin
      if (i_flush) begin
        r_v  <= 1'b0;
        r_gp <= 1'b0;
        r_be <= 1'b0;
      end else if (w_accept) begin
        r_lin     <= w_lin;
        r_dc_addr <= w_lin[31:2];
        r_off     <= w_lin[1:0];
        r_op      <= i_opSize;
        r_split   <= w_split;
        r_data    <= 32'd0;
        // Writes and faulting uops complete immediately with no D-cache read.
        r_v       <= ~w_rd_go;
        r_gp      <= w_fault;
        r_be      <= 1'b0;
      end else if (w_done) begin
        r_v    <= 1'b1;
        r_data <= w_asm;
        r_gp   <= 1'b0;
        r_be   <= 1'b0;
      end else if (w_to_res) begin
        r_v    <= 1'b1;
        r_data <= 32'd0;
        r_be   <= 1'b1;
      end else if (r_v && !i_ex_stall) begin
        r_v  <= 1'b0;
        r_gp <= 1'b0;
        r_be <= 1'b0;
      end

      // First half of a split access: keep the low dword, step to next dword.
      if ((r_state == S_RD0) && i_dc_ack && r_split && !i_flush) begin
        r_lo      <= i_dc_data;
        r_dc_addr <= r_dc_addr + 30'd1;
      end

      if (w_busy && !i_dc_ack && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + c_cnt_w'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_v        = r_v;
  assign o_lin_addr = r_lin;
  assign o_mem_data = r_data;
  assign o_gp_fault = r_gp;
  assign o_bus_err  = r_be;
  assign o_dc_addr  = r_dc_addr;

endmodule
`default_nettype wire
